// File: rtl/mac_tile_db.sv
//==============================================================================
// Module   : mac_tile_db
// Brief    : Double-buffered signed MAC tile for a weight-stationary systolic
//            array: active/shadow weight banks, west-to-east swap, optional
//            saturating accumulation.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mac_tile_db #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,   // must satisfy psum_bw >= 2*bw
    parameter bit sat_en  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      in_w,
    input  logic [2:0]         inst_w,
    input  logic [psum_bw-1:0] in_n,
    output logic [bw-1:0]      out_e,
    output logic [2:0]         inst_e,
    output logic [psum_bw-1:0] out_s,
    output logic               shadow_full
);

    localparam int c_EXT_W = psum_bw + 1 - 2*bw;

    logic [bw-1:0]      a_q, a_d;
    logic [bw-1:0]      bank0_q, bank0_d;
    logic [bw-1:0]      bank1_q, bank1_d;
    logic [psum_bw-1:0] c_q;
    logic [2:0]         inst_q, inst_d;
    logic               act_sel_q, act_sel_d;
    logic               sf_q, sf_d;

    logic               w_swap;
    logic               w_load;
    logic [bw-1:0]      w_act;
    logic [2*bw-1:0]    w_prod;
    logic [psum_bw:0]   w_sum;
    logic               w_ovf;

    // A swap in the same cycle frees the old active bank for an incoming load.
    assign w_swap = inst_w[2] & sf_q;
    assign w_load = inst_w[0] & (~sf_q | inst_w[2]);

    always_comb begin
        a_d       = (inst_w[0] | inst_w[1]) ? in_w : a_q;
        act_sel_d = act_sel_q ^ w_swap;
        bank0_d   = bank0_q;
        bank1_d   = bank1_q;
        if (w_load) begin
            if (act_sel_d) bank0_d = in_w;
            else           bank1_d = in_w;
        end
        if (w_load)      sf_d = 1'b1;
        else if (w_swap) sf_d = 1'b0;
        else             sf_d = sf_q;
        inst_d = {inst_w[2], inst_w[1], inst_w[0] & ~w_load};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            c_q       <= '0;
            inst_q    <= '0;
            bank0_q   <= '0;
            bank1_q   <= '0;
            act_sel_q <= 1'b0;
            sf_q      <= 1'b0;
        end else begin
            a_q       <= a_d;
            c_q       <= in_n;
            inst_q    <= inst_d;
            bank0_q   <= bank0_d;
            bank1_q   <= bank1_d;
            act_sel_q <= act_sel_d;
            sf_q      <= sf_d;
        end
    end

    assign w_act = act_sel_q ? bank1_q : bank0_q;

    // Low 2*bw bits of the sign-extended operands' product equal the signed product.
    assign w_prod = {{bw{a_q[bw-1]}}, a_q} * {{bw{w_act[bw-1]}}, w_act};
    assign w_sum  = {c_q[psum_bw-1], c_q} + {{c_EXT_W{w_prod[2*bw-1]}}, w_prod};
    assign w_ovf  = w_sum[psum_bw] ^ w_sum[psum_bw-1];

    always_comb begin
        out_s = w_sum[psum_bw-1:0];
        if (sat_en && w_ovf) begin
            out_s = w_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                   : {1'b0, {(psum_bw-1){1'b1}}};
        end
    end

    assign out_e       = a_q;
    assign inst_e      = inst_q;
    assign shadow_full = sf_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_tile_db.sv
//==============================================================================
// Module   : tb_mac_tile_db
// Brief    : Vector-table bench for mac_tile_db (wrap and saturating instances).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mac_tile_db;

    localparam int NV = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_w;
    logic [2:0]  inst_w;
    logic [15:0] in_n;

    logic [3:0]  out_e_w,  out_e_s;
    logic [2:0]  inst_e_w, inst_e_s;
    logic [15:0] out_s_w,  out_s_s;
    logic        sf_w,     sf_s;

    always #5 clk = ~clk;

    mac_tile_db #(.bw(4), .psum_bw(16), .sat_en(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
        .out_e(out_e_w), .inst_e(inst_e_w), .out_s(out_s_w), .shadow_full(sf_w)
    );

    mac_tile_db #(.bw(4), .psum_bw(16), .sat_en(1'b1)) u_sat (
        .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
        .out_e(out_e_s), .inst_e(inst_e_s), .out_s(out_s_s), .shadow_full(sf_s)
    );

    typedef struct {
        logic [3:0]  in_w;
        logic [2:0]  inst;
        logic [15:0] in_n;
        logic [3:0]  e_out_e;
        logic [2:0]  e_inst_e;
        logic [15:0] e_wrap;
        logic [15:0] e_sat;
        logic        e_sf;
    } vec_t;

    vec_t vecs [NV];
    vec_t sb [$];
    vec_t e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [3:0] iw, input logic [2:0] inst,
                        input logic [15:0] n, input logic [3:0] oe, input logic [2:0] ie,
                        input logic [15:0] sw, input logic [15:0] ss, input logic sf);
        vecs[i].in_w     = iw;
        vecs[i].inst     = inst;
        vecs[i].in_n     = n;
        vecs[i].e_out_e  = oe;
        vecs[i].e_inst_e = ie;
        vecs[i].e_wrap   = sw;
        vecs[i].e_sat    = ss;
        vecs[i].e_sf     = sf;
    endtask

    initial begin
        //       idx in_w  inst    in_n      out_e inst_e  wrap      sat       sf
        setv( 0, 4'h3, 3'b001, 16'h0000, 4'h3, 3'b000, 16'd0,    16'd0,    1'b1);
        setv( 1, 4'h5, 3'b001, 16'h0000, 4'h5, 3'b001, 16'd0,    16'd0,    1'b1);
        setv( 2, 4'h0, 3'b100, 16'h0000, 4'h5, 3'b100, 16'd15,   16'd15,   1'b0);
        setv( 3, 4'hE, 3'b010, 16'd10,   4'hE, 3'b010, 16'd4,    16'd4,    1'b0);
        setv( 4, 4'h2, 3'b010, 16'h0000, 4'h2, 3'b010, 16'd6,    16'd6,    1'b0);
        setv( 5, 4'h7, 3'b001, 16'h0000, 4'h7, 3'b000, 16'd21,   16'd21,   1'b1);
        setv( 6, 4'h2, 3'b010, 16'h0000, 4'h2, 3'b010, 16'd6,    16'd6,    1'b1);
        setv( 7, 4'h0, 3'b100, 16'h0000, 4'h2, 3'b100, 16'd14,   16'd14,   1'b0);
        setv( 8, 4'h0, 3'b100, 16'h0000, 4'h2, 3'b100, 16'd14,   16'd14,   1'b0);
        setv( 9, 4'h3, 3'b001, 16'h0000, 4'h3, 3'b000, 16'd21,   16'd21,   1'b1);
        setv(10, 4'h0, 3'b100, 16'h0000, 4'h3, 3'b100, 16'd9,    16'd9,    1'b0);
        setv(11, 4'h7, 3'b001, 16'h0000, 4'h7, 3'b000, 16'd21,   16'd21,   1'b1);
        setv(12, 4'h2, 3'b101, 16'h0000, 4'h2, 3'b100, 16'd14,   16'd14,   1'b1);
        setv(13, 4'h0, 3'b100, 16'h0000, 4'h2, 3'b100, 16'd4,    16'd4,    1'b0);
        setv(14, 4'h5, 3'b101, 16'h0000, 4'h5, 3'b100, 16'd10,   16'd10,   1'b1);
        setv(15, 4'h0, 3'b100, 16'h0000, 4'h5, 3'b100, 16'd25,   16'd25,   1'b0);
        setv(16, 4'h7, 3'b001, 16'h0000, 4'h7, 3'b000, 16'd35,   16'd35,   1'b1);
        setv(17, 4'h0, 3'b100, 16'h7FFE, 4'h7, 3'b100, 16'h802F, 16'h7FFF, 1'b0);
        setv(18, 4'h8, 3'b010, 16'h8000, 4'h8, 3'b010, 16'h7FC8, 16'h8000, 1'b0);
        setv(19, 4'hF, 3'b010, 16'h0005, 4'hF, 3'b010, 16'hFFFE, 16'hFFFE, 1'b0);

        reset  = 1'b0;
        in_w   = '0;
        inst_w = '0;
        in_n   = '0;
        #2;
        chk("rst_out_e",  0, {12'd0, out_e_w},  16'd0);
        chk("rst_inst_e", 0, {13'd0, inst_e_w}, 16'd0);
        chk("rst_out_s",  0, out_s_w,           16'd0);
        chk("rst_sf",     0, {15'd0, sf_w},     16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            in_w   = vecs[i].in_w;
            inst_w = vecs[i].inst;
            in_n   = vecs[i].in_n;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("out_e",      i, {12'd0, out_e_w},  {12'd0, e.e_out_e});
            chk("inst_e",     i, {13'd0, inst_e_w}, {13'd0, e.e_inst_e});
            chk("out_s_wrap", i, out_s_w,           e.e_wrap);
            chk("out_s_sat",  i, out_s_s,           e.e_sat);
            chk("sf",         i, {15'd0, sf_w},     {15'd0, e.e_sf});
            chk("sf_sat",     i, {15'd0, sf_s},     {15'd0, e.e_sf});
        end

        // Asynchronous reset mid-load: outputs clear without a clock edge.
        in_w   = 4'h6;
        inst_w = 3'b001;
        in_n   = 16'h1234;
        @(posedge clk);
        #3;
        chk("pre_rst_sf", 0, {15'd0, sf_w}, 16'd1);
        reset = 1'b0;
        #1;
        chk("arst_out_e",  0, {12'd0, out_e_w},  16'd0);
        chk("arst_inst_e", 0, {13'd0, inst_e_w}, 16'd0);
        chk("arst_out_s",  0, out_s_w,           16'd0);
        chk("arst_out_s2", 0, out_s_s,           16'd0);
        chk("arst_sf",     0, {15'd0, sf_w},     16'd0);
        #1;
        reset  = 1'b1;
        in_w   = 4'h3;
        inst_w = 3'b010;
        in_n   = 16'd4;
        @(posedge clk);
        #1;
        // Banks were discarded, so the product term is zero.
        chk("post_rst_out_s",  0, out_s_w,           16'd4);
        chk("post_rst_out_e",  0, {12'd0, out_e_w},  16'd3);
        chk("post_rst_inst_e", 0, {13'd0, inst_e_w}, 16'd2);
        chk("post_rst_sf",     0, {15'd0, sf_w},     16'd0);
        in_w   = 4'h0;
        inst_w = 3'b100;
        in_n   = 16'd0;
        @(posedge clk);
        #1;
        chk("post_rst_swap_s",  0, out_s_w,           16'd0);
        chk("post_rst_swap_ie", 0, {13'd0, inst_e_w}, 16'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
